instruction_encoder_loader: RTL and testbench

Inverse of the mini-RISC instruction field decode. It accepts per-instruction field bundles plus a format select, packs them into 32-bit instruction words, and writes them sequentially into instruction memory. A start command sets the base address and instruction count. Used by the test and boot path to load programs into the KGP mini-RISC instruction memory.

---
 rtl/instruction_encoder_loader.sv | 140 ++++++++++++++
 tb/tb_instruction_encoder_loader.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder_loader.sv
// Packs mini-RISC field bundles into 32-bit instruction words and
// streams them into instruction memory from a captured base address.
module instruction_encoder_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   num_instr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        fmt,
   input  logic [5:0]        opcode,
   input  logic [5:0]        func,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        shamt,
   input  logic [14:0]       imm_reg,
   input  logic [15:0]       imm_mem,
   input  logic [25:0]       label_addr,
   input  logic [20:0]       comp_addr,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   written_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              err_q, err_d;

   logic [31:0] packed_w;
   logic        legal;
   logic        accept;

   // Fields not owned by the selected format stay zero.
   always_comb begin
      packed_w = '0;
      legal    = 1'b1;
      unique case (fmt)
         3'd0: packed_w = {opcode, rs, rt, 5'b0, shamt, func};
         3'd1: packed_w = {opcode, rs, imm_reg, func};
         3'd2: packed_w = {opcode, rs, rt, imm_mem};
         3'd3: packed_w = {opcode, label_addr};
         3'd4: packed_w = {opcode, rs, comp_addr};
         default: legal = 1'b0;
      endcase
   end

   assign in_ready = (state_q == LOAD) && (rem_q != '0);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               ptr_d   = base_addr;
               rem_d   = num_instr;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = (num_instr != '0) ? LOAD : FLUSH;
            end
         end
         LOAD: begin
            if (accept) begin
               rem_d = rem_q - 1'b1;
               if (legal) begin
                  we_d    = 1'b1;
                  addr_d  = ptr_q;
                  wdata_d = packed_w;
                  ptr_d   = ptr_q + 1'b1;
                  cnt_d   = cnt_q + 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (rem_q == '0) begin
               // Extra LOAD cycle lets the final write land before done.
               state_d = FLUSH;
            end
         end
         FLUSH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         addr_q  <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         err_q   <= err_d;
      end
   end

   assign imem_we       = we_q;
   assign imem_addr     = addr_q;
   assign imem_wdata    = wdata_q;
   assign busy          = (state_q == LOAD);
   assign done          = (state_q == FLUSH);
   assign err           = err_q;
   assign written_count = cnt_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Bench for instruction_encoder_loader: directed and random loads
// checked against a cycle-scheduled behavioural model.
module tb_instruction_encoder_loader;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   num_instr;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    fmt;
   logic [5:0]    opcode;
   logic [5:0]    func;
   logic [4:0]    rs;
   logic [4:0]    rt;
   logic [4:0]    shamt;
   logic [14:0]   imm_reg;
   logic [15:0]   imm_mem;
   logic [25:0]   label_addr;
   logic [20:0]   comp_addr;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW:0]   written_count;

   instruction_encoder_loader #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .base_addr(base_addr), .num_instr(num_instr),
      .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .func(func),
      .rs(rs), .rt(rt), .shamt(shamt),
      .imm_reg(imm_reg), .imm_mem(imm_mem),
      .label_addr(label_addr), .comp_addr(comp_addr),
      .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .busy(busy), .done(done),
      .err(err), .written_count(written_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  sh;
      logic [5:0]  fn;
      logic [14:0] ir;
      logic [15:0] im;
      logic [25:0] la;
      logic [20:0] ca;
   } bnd_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   logic [31:0]   exp_data[int];
   logic [AW-1:0] exp_addr[int];
   bit            exp_done[int];

   logic [AW-1:0] m_ptr;
   logic [AW-1:0] m_last_addr;
   logic [31:0]   m_last_data;
   logic [AW:0]   m_rem;
   logic [AW:0]   m_cnt;
   logic          m_err;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("imem_we", imem_we, exp_data.exists(cyc) ? 1 : 0);
         if (exp_data.exists(cyc)) begin
            chk("imem_addr", imem_addr, exp_addr[cyc]);
            chk("imem_wdata", imem_wdata, exp_data[cyc]);
         end
         chk("done", done, exp_done.exists(cyc) ? 1 : 0);
      end
   end

   // Reference packing: each field shifted to its bit position.
   function automatic logic [32:0] enc(input bnd_t b);
      logic [31:0] w;
      logic        ok;
      ok = 1'b1;
      w  = 32'(b.op) << 26;
      case (b.f)
         3'd0: w = w + (32'(b.rs) << 21) + (32'(b.rt) << 16)
                 + (32'(b.sh) << 6) + 32'(b.fn);
         3'd1: w = w + (32'(b.rs) << 21) + (32'(b.ir) << 6) + 32'(b.fn);
         3'd2: w = w + (32'(b.rs) << 21) + (32'(b.rt) << 16) + 32'(b.im);
         3'd3: w = w + 32'(b.la);
         3'd4: w = w + (32'(b.rs) << 21) + 32'(b.ca);
         default: begin
            ok = 1'b0;
            w  = '0;
         end
      endcase
      return {ok, w};
   endfunction

   function automatic bnd_t mk(input int f, input int op, input int r1,
                               input int r2, input int sh, input int fn,
                               input int ir, input int im, input int la,
                               input int ca);
      bnd_t b;
      b.f  = 3'(f);
      b.op = 6'(op);
      b.rs = 5'(r1);
      b.rt = 5'(r2);
      b.sh = 5'(sh);
      b.fn = 6'(fn);
      b.ir = 15'(ir);
      b.im = 16'(im);
      b.la = 26'(la);
      b.ca = 21'(ca);
      return b;
   endfunction

   function automatic bnd_t rnd_bnd();
      return mk($urandom_range(0, 7), $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_cmd(input int base, input int num);
      start     = 1'b1;
      base_addr = AW'(base);
      num_instr = (AW + 1)'(num);
      tick();
      start  = 1'b0;
      m_ptr  = AW'(base);
      m_rem  = (AW + 1)'(num);
      m_cnt  = '0;
      m_err  = 1'b0;
      if (num == 0) exp_done[cyc] = 1'b1;
      chk("err_after_start", err, 0);
      chk("cnt_after_start", written_count, 0);
   endtask

   task automatic send(input bnd_t b, input bit v, input bit st);
      logic [32:0] r;
      int          c;
      fmt        = b.f;
      opcode     = b.op;
      rs         = b.rs;
      rt         = b.rt;
      shamt      = b.sh;
      func       = b.fn;
      imm_reg    = b.ir;
      imm_mem    = b.im;
      label_addr = b.la;
      comp_addr  = b.ca;
      in_valid   = v;
      start      = st;
      base_addr  = AW'($urandom);
      num_instr  = (AW + 1)'($urandom_range(0, 3));
      @(negedge clk);
      chk("in_ready", in_ready, (m_rem != 0) ? 1 : 0);
      if (m_rem != 0) chk("busy_load", busy, 1);
      c = cyc;
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
      if (v && m_rem != 0) begin
         r = enc(b);
         m_rem--;
         if (r[32]) begin
            exp_data[c + 1] = r[31:0];
            exp_addr[c + 1] = m_ptr;
            m_last_addr     = m_ptr;
            m_last_data     = r[31:0];
            m_ptr++;
            m_cnt++;
         end else begin
            m_err = 1'b1;
         end
         if (m_rem == 0) exp_done[c + 2] = 1'b1;
      end
   endtask

   task automatic send_k(input string tag, input bnd_t b,
                         input logic [31:0] w);
      send(b, 1'b1, 1'b0);
      chk(tag, imem_wdata, w);
   endtask

   task automatic finish_load(input int pre);
      repeat (pre) tick();
      @(negedge clk);
      chk("written_count", written_count, m_cnt);
      chk("err", err, m_err);
      tick();
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
      chk("hold_addr", imem_addr, m_last_addr);
      chk("hold_data", imem_wdata, m_last_data);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bnd_t b;
      int   n;
      rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      num_instr = '0;
      send_idle_defaults: begin
         in_valid = 1'b0;
         b = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         fmt = b.f; opcode = b.op; rs = b.rs; rt = b.rt;
         shamt = b.sh; func = b.fn; imm_reg = b.ir;
         imm_mem = b.im; label_addr = b.la; comp_addr = b.ca;
      end
      m_ptr = '0; m_rem = '0; m_cnt = '0; m_err = 1'b0;
      m_last_addr = '0; m_last_data = '0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_we", imem_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_wdata", imem_wdata, 0);
      chk("rst_cnt", written_count, 0);
      tick();
      rst = 1'b0;
      mon_en = 1'b1;
      tick();

      start_cmd(0, 5);
      send_k("tp_r", mk(0, 0, 1, 2, 0, 1, 0, 0, 0, 0), 32'h00220001);
      send_k("tp_ri", mk(1, 1, 2, 0, 0, 2, 'h7FFF, 0, 0, 0),
             32'h045FFFC2);
      send_k("tp_mem", mk(2, 4, 3, 4, 0, 0, 0, 'hFFFC, 0, 0),
             32'h1064FFFC);
      send_k("tp_jmp", mk(3, 'h0C, 0, 0, 0, 0, 0, 0, 'h10, 0),
             32'h30000010);
      send_k("tp_br", mk(4, 'h0D, 5, 0, 0, 0, 0, 0, 0, 'h1FFFFF),
             32'h34BFFFFF);
      finish_load(1);

      start_cmd('h010, 1);
      send_k("garbage_r", mk(0, 0, 1, 2, 0, 1, 'h7FFF, 'hFFFF,
             'h3FFFFFF, 'h1FFFFF), 32'h00220001);
      finish_load(1);

      start_cmd('h3FF, 2);
      send(mk(0, 1, 3, 4, 5, 6, 0, 0, 0, 0), 1'b1, 1'b0);
      chk("wrap_addr0", imem_addr, 'h3FF);
      send(mk(0, 2, 7, 8, 9, 10, 0, 0, 0, 0), 1'b1, 1'b0);
      chk("wrap_addr1", imem_addr, 'h000);
      finish_load(1);

      start_cmd('h020, 3);
      send(mk(0, 3, 1, 1, 1, 1, 0, 0, 0, 0), 1'b1, 1'b0);
      send(mk(6, 3, 1, 1, 1, 1, 0, 0, 0, 0), 1'b1, 1'b0);
      send(mk(0, 4, 2, 2, 2, 2, 0, 0, 0, 0), 1'b1, 1'b0);
      chk("illegal_addr", imem_addr, 'h021);
      finish_load(1);
      chk("err_sticky", err, 1);
      start_cmd('h030, 1);
      send(rnd_bnd(), 1'b1, 1'b0);
      finish_load(1);

      start_cmd('h040, 2);
      send(mk(0, 5, 1, 2, 3, 4, 0, 0, 0, 0), 1'b1, 1'b0);
      send(mk(0, 6, 1, 2, 3, 4, 0, 0, 0, 0), 1'b0, 1'b1);
      send(mk(2, 7, 1, 2, 0, 0, 0, 'h1234, 0, 0), 1'b1, 1'b0);
      finish_load(1);

      start_cmd('h050, 0);
      finish_load(0);

      for (int k = 0; k < 6; k++) begin
         n = $urandom_range(1, 6);
         start_cmd($urandom_range(0, 1023), n);
         while (m_rem != 0)
            send(rnd_bnd(), $urandom_range(0, 3) != 0, 1'b0);
         finish_load(1);
      end

      start_cmd('h100, 4);
      send(mk(0, 1, 1, 1, 1, 1, 0, 0, 0, 0), 1'b1, 1'b0);
      send(mk(0, 2, 2, 2, 2, 2, 0, 0, 0, 0), 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      m_rem = '0; m_ptr = '0; m_cnt = '0; m_err = 1'b0;
      m_last_addr = '0; m_last_data = '0;
      @(negedge clk);
      chk("mrst_we", imem_we, 0);
      chk("mrst_ready", in_ready, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_addr", imem_addr, 0);
      chk("mrst_wdata", imem_wdata, 0);
      chk("mrst_cnt", written_count, 0);
      tick();
      rst = 1'b0;
      send(rnd_bnd(), 1'b1, 1'b0);
      send(rnd_bnd(), 1'b1, 1'b0);
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
